// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared constants and helpers for the clk_div integer clock divider
package clk_div_pkg;

    // Largest divide ratio the 16-bit counter path is sized for
    localparam int DIV_MAX = 65535;

    // Counter width for a given ratio; never narrower than one bit
    function automatic int cnt_width(input int div);
        int w;
        w = $clog2(div);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/clk_div_cnt.sv
// rtl/clk_div_cnt.sv - modulo-DIV counter with wrap flag (wrap_next port only with CLK_DIV_TICK_EN)
module clk_div_cnt
    import clk_div_pkg::*;
#(
    parameter  int DIV   = 3,
    localparam int CNT_W = cnt_width(DIV)
) (
    input  logic             clk_in,
    input  logic             rst_n,
    output logic [CNT_W-1:0] cnt
`ifdef CLK_DIV_TICK_EN
    ,
    output logic             wrap_next
`endif
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;
    logic             wrap;

    // Next count: wrap to zero after the last source cycle of the period
    always_comb begin
        wrap  = (cnt_q == LAST);
        cnt_d = wrap ? '0 : cnt_q + ONE;
`ifdef CLK_DIV_TICK_EN
        // Asserted when the count is about to land on its last value, so a
        // flop fed by it lines up with cnt == DIV-1
        wrap_next = (cnt_d == LAST);
`endif
    end

    // Counter register, cleared asynchronously so every restart begins at 0
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/clk_div.sv
// rtl/clk_div.sv - 50% duty integer clock divider; CLK_DIV_TICK_EN adds the div_tick output
module clk_div
    import clk_div_pkg::*;
#(
    parameter int DIV = 3
) (
    input  logic clk_in,
    input  logic rst_n,
    output logic clk_out
`ifdef CLK_DIV_TICK_EN
    ,
    output logic div_tick
`endif
);

    if (DIV < 1 || DIV > DIV_MAX) begin : g_bad_div
        $fatal(1, "clk_div: DIV=%0d outside 1..%0d", DIV, DIV_MAX);
    end

    if (DIV == 1) begin : g_bypass
        // Divide-by-one passes the source straight through, gated low in reset
        assign clk_out = clk_in & rst_n;

`ifdef CLK_DIV_TICK_EN
        logic tick_d;
        logic tick_q;

        // Every source cycle is a full output period, so the tick is simply rst_n
        always_comb tick_d = rst_n;

        // Tick register
        always_ff @(posedge clk_in or negedge rst_n) begin
            if (!rst_n) begin
                tick_q <= 1'b0;
            end else begin
                tick_q <= tick_d;
            end
        end

        assign div_tick = tick_q;
`endif
    end else begin : g_div
        localparam int               CNT_W = cnt_width(DIV);
        localparam logic [CNT_W-1:0] HALF  = CNT_W'(DIV / 2);

        logic [CNT_W-1:0] cnt;
        logic             pos_d;
        logic             pos_q;
`ifdef CLK_DIV_TICK_EN
        logic             wrap_next;
`endif

        clk_div_cnt #(
            .DIV (DIV)
        ) u_cnt (
            .clk_in    (clk_in),
            .rst_n     (rst_n),
            .cnt       (cnt)
`ifdef CLK_DIV_TICK_EN
            ,
            .wrap_next (wrap_next)
`endif
        );

        // High phase covers the first floor(DIV/2) counts of each period
        always_comb pos_d = (cnt < HALF);

        // Rising-edge phase flop; drives clk_out directly for even ratios
        always_ff @(posedge clk_in or negedge rst_n) begin
            if (!rst_n) begin
                pos_q <= 1'b0;
            end else begin
                pos_q <= pos_d;
            end
        end

        if (DIV % 2 == 0) begin : g_even
            assign clk_out = pos_q;
        end else begin : g_odd
            logic neg_d;
            logic neg_q;

            // Half-cycle stretch: copy the phase half a source cycle later
            always_comb neg_d = pos_q;

            // Falling-edge stretch register, extends the high phase by half a cycle
            always_ff @(negedge clk_in or negedge rst_n) begin
                if (!rst_n) begin
                    neg_q <= 1'b0;
                end else begin
                    neg_q <= neg_d;
                end
            end

            // Two flops ORed: high for H+0.5 cycles, low for H+0.5 cycles
            assign clk_out = pos_q | neg_q;
        end

`ifdef CLK_DIV_TICK_EN
        logic tick_d;
        logic tick_q;

        // Tick is set on the edge where the counter reaches DIV-1
        always_comb tick_d = wrap_next;

        // Tick register, one source cycle wide per output period
        always_ff @(posedge clk_in or negedge rst_n) begin
            if (!rst_n) begin
                tick_q <= 1'b0;
            end else begin
                tick_q <= tick_d;
            end
        end

        assign div_tick = tick_q;
`endif
    end

endmodule

// File: tb/tb_clk_div.sv
// tb/tb_clk_div.sv - self-checking bench for clk_div at DIV=1,3,4,5 (div_tick checked with CLK_DIV_TICK_EN)
module tb_clk_div;

    logic       clk_in = 1'b0;
    logic       rst_n;
    logic [3:0] co;
`ifdef CLK_DIV_TICK_EN
    logic [3:0] tk;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        logic [3:0] clk;
        logic [3:0] tick;
    } exp_t;

    exp_t sb[$];

    clk_div #(.DIV(1)) u_d1 (
        .clk_in (clk_in), .rst_n (rst_n), .clk_out (co[0])
`ifdef CLK_DIV_TICK_EN
        , .div_tick (tk[0])
`endif
    );
    clk_div #(.DIV(3)) u_d3 (
        .clk_in (clk_in), .rst_n (rst_n), .clk_out (co[1])
`ifdef CLK_DIV_TICK_EN
        , .div_tick (tk[1])
`endif
    );
    clk_div #(.DIV(4)) u_d4 (
        .clk_in (clk_in), .rst_n (rst_n), .clk_out (co[2])
`ifdef CLK_DIV_TICK_EN
        , .div_tick (tk[2])
`endif
    );
    clk_div #(.DIV(5)) u_d5 (
        .clk_in (clk_in), .rst_n (rst_n), .clk_out (co[3])
`ifdef CLK_DIV_TICK_EN
        , .div_tick (tk[3])
`endif
    );

    always #10 clk_in = ~clk_in;

    function automatic int div_of(input int i);
        case (i)
            0:       return 1;
            1:       return 3;
            2:       return 4;
            default: return 5;
        endcase
    endfunction

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [3:0] c, input logic [3:0] t);
        exp_t e;
        e.tag  = tag;
        e.clk  = c;
        e.tick = t;
        sb.push_back(e);
    endtask

    task automatic pop_compare();
        exp_t e;
        checks++;
        assert (sb.size() > 0) else begin
            errors++;
            $error("FAIL scoreboard_empty observed=%0d expected=>0", sb.size());
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            for (int i = 0; i < 4; i++) begin
                check_bit($sformatf("%s clk_out div%0d", e.tag, div_of(i)), co[i], e.clk[i]);
`ifdef CLK_DIV_TICK_EN
                check_bit($sformatf("%s div_tick div%0d", e.tag, div_of(i)), tk[i], e.tick[i]);
`endif
            end
        end
    endtask

    // Hold reset for a number of source cycles, sampling both phases, then release in the low phase
    task automatic reset_phase(input string tag, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            push($sformatf("%s c%0d hi", tag, c), 4'b0000, 4'b0000);
            @(posedge clk_in);
            #5;
            pop_compare();
            push($sformatf("%s c%0d lo", tag, c), 4'b0000, 4'b0000);
            @(negedge clk_in);
            #5;
            pop_compare();
        end
        rst_n = 1'b1;
    endtask

    // n counts half cycles from the first rising edge after release:
    // clk_out is high for the first DIV half cycles of every 2*DIV,
    // div_tick is high in the source cycle r where (r+1) mod DIV == DIV-1
    task automatic run_phase(input string tag, input int halves);
        logic [3:0] ec;
        logic [3:0] et;
        int         d;
        for (int n = 0; n < halves; n++) begin
            for (int i = 0; i < 4; i++) begin
                d     = div_of(i);
                ec[i] = ((n % (2 * d)) < d);
                et[i] = (d == 1) ? 1'b1 : (((n / 2) % d) == d - 2);
            end
            push($sformatf("%s n%0d", tag, n), ec, et);
            if (n % 2 == 0) begin
                @(posedge clk_in);
            end else begin
                @(negedge clk_in);
            end
            #5;
            pop_compare();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        #1;
        push("reset t1", 4'b0000, 4'b0000);
        pop_compare();

        reset_phase("reset", 2);
        run_phase("run1", 37);

        // Sampled just after a rising edge where DIV=3 is mid high phase
        check_bit("div3 high before midreset", co[1], 1'b1);
        rst_n = 1'b0;
        #1;
        push("midreset", 4'b0000, 4'b0000);
        pop_compare();

        reset_phase("reset2", 2);
        run_phase("run2", 40);

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
